game_collision_ctrl: RTL and testbench
======================================

# game_collision_ctrl

Game-state controller sitting directly downstream of the car position block. Each frame it samples the car position (`car_h_pos`/`car_v_pos`) and up to two obstacle positions, and detects bounding-box overlap. It runs the IDLE/RUN/CRASH/OVER game state machine, keeps the score, and drives the `reset_game` input of the car position block.

## Interface
Parameters:
- `CAR_W`, 50, car width in pixels
- `CAR_H`, 80, car height in pixels
- `OBS_W`, 50, obstacle width in pixels
- `OBS_H`, 80, obstacle height in pixels
- `CRASH_FRAMES`, 120, frames spent in CRASH before OVER
- `FLASH_DIV`, 8, `crash_flash` toggle period in frames
- `SCORE_MAX`, 9999, score saturation value

Ports:
- `iVGA_CLK`  in  1  single clock
- `iRST`  in  1  reset; synchronous and active-high; one clock
- `frame_tick`  in  1  one-cycle pulse per frame (end of active video)
- `start_key`  in  1  level from the start button; rising edge detected internally
- `car_h_pos`  in  10  car left edge
- `car_v_pos`  in  9  car top edge
- `obs_h[1:0]`  in  2×10  obstacle left edges
- `obs_v[1:0]`  in  2×9  obstacle top edges
- `obs_valid`  in  2  per-obstacle enable
- `reset_game`  out  1  to the car block; high in IDLE and in RESTART
- `game_over`  out  1  high in OVER
- `crash_flash`  out  1  blink signal during CRASH
- `hit`  out  1  registered overlap flag for the last evaluated frame
- `score`  out  14  frames survived, saturating

## Operation
- States: IDLE, RUN, CRASH, OVER, RESTART.
- Start detection: `start_rise = start_key & ~start_q`. `start_q` is a registered copy of `start_key`.
- IDLE:
  - `reset_game=1`, score held at 0.
  - `start_rise` → RUN.
- RUN:
  - On `frame_tick`, snapshot all position inputs into registers (cycle T+1).
  - At T+2, register `hit` = OR over valid obstacles of the overlap result.
  - At T+2, if `hit`=0, score increments, saturating at `SCORE_MAX`.
  - If `hit`=1 → CRASH, frame counter cleared, `crash_flash`=1.
- Overlap rule:
  - `car_h < obs_h+OBS_W && obs_h < car_h+CAR_W && car_v < obs_v+OBS_H && obs_v < car_v+CAR_H`.
  - All sums are evaluated at 11 bits; no wrap.
  - Edges that only touch do not count as a hit.
- CRASH:
  - Count `frame_tick`s.
  - Toggle `crash_flash` every `FLASH_DIV` ticks.
  - After `CRASH_FRAMES` ticks → OVER, `crash_flash`=0.
  - Score frozen.
- OVER:
  - `game_over=1`, score held.
  - `start_rise` → RESTART.
- RESTART:
  - Lasts exactly one cycle.
  - `reset_game=1`, score cleared, snapshot cleared.
  - Next state RUN.
- Simultaneous events:
  - `start_rise` in OVER together with `frame_tick`: restart wins, the tick is ignored.
  - `frame_tick` arriving while the evaluation of the previous tick is pending: cannot occur (ticks are ≥2 cycles apart); behaviour is unspecified.
- `start_rise` in RUN or CRASH is ignored.

## Timing
- Reset values:
  - state IDLE, `reset_game=1`, `game_over=0`, `crash_flash=0`, `hit=0`, `score=0`.
  - `start_q=0` and counters at 0.
- Latency:
  - `frame_tick` at T → `hit`/`score` valid at T+2.
  - State is CRASH at T+3.
- `start_rise` at T → RUN/RESTART at T+1. The `reset_game` pulse from RESTART is exactly 1 cycle.
- Reset mid-operation: `iRST` overrides everything in the same edge → IDLE, all outputs at reset values.

## Configuration
- `GAME_INVINCIBLE_EN` defined:
  - `hit` is still computed and output.
  - RUN never transitions to CRASH.
  - Score increments on every evaluated frame regardless of hit.
- `GAME_INVINCIBLE_EN` undefined: behaviour exactly as described under Operation.

## Structure
- Shared package `game_pkg`:
  - state enum `game_state_t`.
  - default car/obstacle dimensions.
  - playfield width constants: 10-bit horizontal, 9-bit vertical, 11-bit extended.
- Sub-module `box_overlap`: combinational AABB comparator with width parameters, instantiated once per obstacle.

## Test plan
- Reset release, `start_key` pulse → `reset_game` 1→0 one cycle after `start_rise`; state RUN, score 0.
- RUN, car (295,400), obstacle0 (120,100) valid, 10 ticks → `hit`=0, score=10.
- Car (295,400), obstacle0 (300,350), tick at T → `hit`=1 at T+2, CRASH at T+3, score unchanged.
- Touching edges: car (295,400), obstacle (345,400) → no hit. Obstacle (344,400) → hit.
- CRASH with `CRASH_FRAMES`=120, `FLASH_DIV`=8 → `crash_flash` toggles 15 times; OVER on tick 120. Then `start_rise` → one-cycle `reset_game`, score 0, RUN.
- `iRST` asserted mid-CRASH → next edge IDLE, all outputs at reset values. Score pinned at 9999 after 10000 clean ticks.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared types and playfield constants for the collision controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_CRASH   = 3'd2,
      ST_OVER    = 3'd3,
      ST_RESTART = 3'd4
   } game_state_t;

   localparam int CAR_W_DEF = 50;
   localparam int CAR_H_DEF = 80;
   localparam int OBS_W_DEF = 50;
   localparam int OBS_H_DEF = 80;

   localparam int H_W = 10;
   localparam int V_W = 9;
   localparam int X_W = 11;

endpackage

`default_nettype wire

// File: rtl/game_collision_ctrl_box_overlap.sv
// ============================================================================
// box_overlap : combinational axis-aligned bounding-box overlap test
// Revision    : 1.0
// ============================================================================
`default_nettype none

module box_overlap
   import game_pkg::*;
#(
   parameter int A_W = CAR_W_DEF,
   parameter int A_H = CAR_H_DEF,
   parameter int B_W = OBS_W_DEF,
   parameter int B_H = OBS_H_DEF
) (
   input  logic [H_W-1:0] a_h_i,
   input  logic [V_W-1:0] a_v_i,
   input  logic [H_W-1:0] b_h_i,
   input  logic [V_W-1:0] b_v_i,
   output logic           overlap_o
);

   // Extended width keeps right/bottom edges from wrapping near the field limit
   logic [X_W-1:0] w_a_l, w_a_r, w_a_t, w_a_b;
   logic [X_W-1:0] w_b_l, w_b_r, w_b_t, w_b_b;

   assign w_a_l = X_W'(a_h_i);
   assign w_a_r = X_W'(a_h_i) + X_W'(A_W);
   assign w_a_t = X_W'(a_v_i);
   assign w_a_b = X_W'(a_v_i) + X_W'(A_H);
   assign w_b_l = X_W'(b_h_i);
   assign w_b_r = X_W'(b_h_i) + X_W'(B_W);
   assign w_b_t = X_W'(b_v_i);
   assign w_b_b = X_W'(b_v_i) + X_W'(B_H);

   assign overlap_o = (w_a_l < w_b_r) && (w_b_l < w_a_r) &&
                      (w_a_t < w_b_b) && (w_b_t < w_a_b);

endmodule

`default_nettype wire

// File: rtl/game_collision_ctrl.sv
// ============================================================================
// game_collision_ctrl : per-frame collision check, game FSM and score keeping
// Option : GAME_INVINCIBLE_EN keeps RUN alive and scores every frame
// Revision : 1.0
// ============================================================================
`default_nettype none

module game_collision_ctrl
   import game_pkg::*;
#(
   parameter int CAR_W        = CAR_W_DEF,
   parameter int CAR_H        = CAR_H_DEF,
   parameter int OBS_W        = OBS_W_DEF,
   parameter int OBS_H        = OBS_H_DEF,
   parameter int CRASH_FRAMES = 120,
   parameter int FLASH_DIV    = 8,
   parameter int SCORE_MAX    = 9999
) (
   input  logic                 iVGA_CLK,
   input  logic                 iRST,
   input  logic                 frame_tick,
   input  logic                 start_key,
   input  logic [H_W-1:0]       car_h_pos,
   input  logic [V_W-1:0]       car_v_pos,
   input  logic [1:0][H_W-1:0]  obs_h,
   input  logic [1:0][V_W-1:0]  obs_v,
   input  logic [1:0]           obs_valid,
   output logic                 reset_game,
   output logic                 game_over,
   output logic                 crash_flash,
   output logic                 hit,
   output logic [13:0]          score
);

   localparam int CNT_W = $clog2(CRASH_FRAMES + 1);
   localparam int FLW_W = $clog2(FLASH_DIV + 1);
   localparam logic [CNT_W-1:0] c_crash_last = CNT_W'(CRASH_FRAMES - 1);
   localparam logic [FLW_W-1:0] c_flash_last = FLW_W'(FLASH_DIV - 1);
   localparam logic [13:0]      c_score_max  = 14'(SCORE_MAX);

   game_state_t           state_q, state_d;
   logic                  start_q;
   logic [H_W-1:0]        car_h_q, car_h_d;
   logic [V_W-1:0]        car_v_q, car_v_d;
   logic [1:0][H_W-1:0]   obs_h_q, obs_h_d;
   logic [1:0][V_W-1:0]   obs_v_q, obs_v_d;
   logic [1:0]            obs_vld_q, obs_vld_d;
   logic                  pend_q, pend_d;
   logic                  eval_q, eval_d;
   logic                  hit_q, hit_d;
   logic [13:0]           score_q, score_d;
   logic [CNT_W-1:0]      crash_cnt_q, crash_cnt_d;
   logic [FLW_W-1:0]      flash_cnt_q, flash_cnt_d;
   logic                  flash_q, flash_d;

   logic                  w_start_rise;
   logic [1:0]            w_ovl;
   logic                  w_hit;
   logic                  w_score_ok;

   assign w_start_rise = start_key & ~start_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_obs
      box_overlap #(
         .A_W (CAR_W),
         .A_H (CAR_H),
         .B_W (OBS_W),
         .B_H (OBS_H)
      ) u_box (
         .a_h_i     (car_h_q),
         .a_v_i     (car_v_q),
         .b_h_i     (obs_h_q[gi]),
         .b_v_i     (obs_v_q[gi]),
         .overlap_o (w_ovl[gi])
      );
   end

   assign w_hit = |(w_ovl & obs_vld_q);

`ifdef GAME_INVINCIBLE_EN
   assign w_score_ok = 1'b1;
`else
   assign w_score_ok = ~w_hit;
`endif

   always_comb begin
      state_d     = state_q;
      car_h_d     = car_h_q;
      car_v_d     = car_v_q;
      obs_h_d     = obs_h_q;
      obs_v_d     = obs_v_q;
      obs_vld_d   = obs_vld_q;
      pend_d      = 1'b0;
      eval_d      = pend_q;
      hit_d       = pend_q ? w_hit : hit_q;
      score_d     = score_q;
      crash_cnt_d = crash_cnt_q;
      flash_cnt_d = flash_cnt_q;
      flash_d     = flash_q;

      if (pend_q && (state_q == ST_RUN) && w_score_ok && (score_q != c_score_max)) begin
         score_d = score_q + 14'd1;
      end

      case (state_q)
         ST_IDLE: begin
            score_d = '0;
            if (w_start_rise) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (frame_tick) begin
               car_h_d   = car_h_pos;
               car_v_d   = car_v_pos;
               obs_h_d   = obs_h;
               obs_v_d   = obs_v;
               obs_vld_d = obs_valid;
               pend_d    = 1'b1;
            end
`ifndef GAME_INVINCIBLE_EN
            // eval_q marks the cycle where hit_q holds a fresh result
            if (eval_q && hit_q) begin
               state_d     = ST_CRASH;
               crash_cnt_d = '0;
               flash_cnt_d = '0;
               flash_d     = 1'b1;
            end
`endif
         end
         ST_CRASH: begin
            if (frame_tick) begin
               crash_cnt_d = crash_cnt_q + 1'b1;
               if (crash_cnt_q == c_crash_last) begin
                  state_d = ST_OVER;
                  flash_d = 1'b0;
               end else if (flash_cnt_q == c_flash_last) begin
                  flash_cnt_d = '0;
                  flash_d     = ~flash_q;
               end else begin
                  flash_cnt_d = flash_cnt_q + 1'b1;
               end
            end
         end
         ST_OVER: begin
            if (w_start_rise) begin
               state_d = ST_RESTART;
            end
         end
         ST_RESTART: begin
            state_d   = ST_RUN;
            score_d   = '0;
            car_h_d   = '0;
            car_v_d   = '0;
            obs_h_d   = '0;
            obs_v_d   = '0;
            obs_vld_d = '0;
            pend_d    = 1'b0;
            eval_d    = 1'b0;
            hit_d     = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iVGA_CLK) begin
      if (iRST) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         car_h_q     <= '0;
         car_v_q     <= '0;
         obs_h_q     <= '0;
         obs_v_q     <= '0;
         obs_vld_q   <= '0;
         pend_q      <= 1'b0;
         eval_q      <= 1'b0;
         hit_q       <= 1'b0;
         score_q     <= '0;
         crash_cnt_q <= '0;
         flash_cnt_q <= '0;
         flash_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_key;
         car_h_q     <= car_h_d;
         car_v_q     <= car_v_d;
         obs_h_q     <= obs_h_d;
         obs_v_q     <= obs_v_d;
         obs_vld_q   <= obs_vld_d;
         pend_q      <= pend_d;
         eval_q      <= eval_d;
         hit_q       <= hit_d;
         score_q     <= score_d;
         crash_cnt_q <= crash_cnt_d;
         flash_cnt_q <= flash_cnt_d;
         flash_q     <= flash_d;
      end
   end

   assign reset_game  = (state_q == ST_IDLE) || (state_q == ST_RESTART);
   assign game_over   = (state_q == ST_OVER);
   assign crash_flash = flash_q;
   assign hit         = hit_q;
   assign score       = score_q;

endmodule

`default_nettype wire

// File: tb/tb_game_collision_ctrl.sv
// ============================================================================
// tb_game_collision_ctrl : directed + randomized bench with a frame-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_game_collision_ctrl;

   localparam int CW = 50;
   localparam int CH = 80;
   localparam int OW = 50;
   localparam int OH = 80;
   localparam int CF = 120;
   localparam int FD = 8;
   localparam int SMAX = 9999;

   logic             clk = 1'b0;
   logic             iRST;
   logic             frame_tick;
   logic             start_key;
   logic [9:0]       car_h_pos;
   logic [8:0]       car_v_pos;
   logic [1:0][9:0]  obs_h;
   logic [1:0][8:0]  obs_v;
   logic [1:0]       obs_valid;
   logic             reset_game;
   logic             game_over;
   logic             crash_flash;
   logic             hit;
   logic [13:0]      score;

   int vectors = 0;
   int errs    = 0;
   int score_m = 0;

   game_collision_ctrl dut (
      .iVGA_CLK    (clk),
      .iRST        (iRST),
      .frame_tick  (frame_tick),
      .start_key   (start_key),
      .car_h_pos   (car_h_pos),
      .car_v_pos   (car_v_pos),
      .obs_h       (obs_h),
      .obs_v       (obs_v),
      .obs_valid   (obs_valid),
      .reset_game  (reset_game),
      .game_over   (game_over),
      .crash_flash (crash_flash),
      .hit         (hit),
      .score       (score)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit ovl(input int ch, input int cv, input int oh, input int ov);
      return (ch < oh + OW) && (oh < ch + CW) && (cv < ov + OH) && (ov < cv + CH);
   endfunction

   task automatic scramble();
      car_h_pos = 10'($urandom);
      car_v_pos = 9'($urandom);
      obs_h[0]  = 10'($urandom);
      obs_h[1]  = 10'($urandom);
      obs_v[0]  = 9'($urandom);
      obs_v[1]  = 9'($urandom);
      obs_valid = 2'($urandom);
   endtask

   task automatic tick_pulse();
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
   endtask

   task automatic start_game();
      @(posedge clk); #1 start_key = 1'b1;
      chk("rg_before_start", reset_game, 1);
      @(posedge clk); #1;
      chk("rg_after_start", reset_game, 0);
      chk("score_after_start", score, 0);
      chk("over_after_start", game_over, 0);
      start_key = 1'b0;
      score_m = 0;
   endtask

   task automatic crash_and_restart();
      int   toggles;
      logic prev;
      toggles = 0;
      prev    = crash_flash;
      for (int k = 1; k <= CF; k++) begin
         if (k == 60) begin
            @(posedge clk); #1 start_key = 1'b1;
            @(posedge clk); #1 start_key = 1'b0;
         end
         tick_pulse();
         if (crash_flash !== prev) toggles++;
         prev = crash_flash;
         chk("crash_flash", crash_flash, (k == CF) ? 0 : (((k / FD) % 2) == 0));
         chk("crash_over", game_over, (k == CF));
         chk("crash_score", score, score_m);
         @(posedge clk);
      end
      chk("flash_toggles", toggles, CF / FD);
      repeat (3) @(posedge clk);
      #1;
      chk("over_hold", game_over, 1);
      chk("over_rg", reset_game, 0);
      // restart request coincides with a frame tick that must be ignored
      @(posedge clk); #1 start_key = 1'b1; frame_tick = 1'b1;
      car_h_pos = 10'd295; car_v_pos = 9'd400; obs_h[0] = 10'd120; obs_v[0] = 9'd100;
      obs_valid = 2'b01;
      @(posedge clk); #1 start_key = 1'b0; frame_tick = 1'b0;
      chk("restart_rg", reset_game, 1);
      chk("restart_over", game_over, 0);
      @(posedge clk); #1;
      chk("restart_rg_pulse", reset_game, 0);
      chk("restart_score", score, 0);
      @(posedge clk); #1;
      chk("restart_score_hold", score, 0);
      score_m = 0;
   endtask

   task automatic run_frame(input int ch, input int cv, input int oh0, input int ov0,
                            input int oh1, input int ov1, input int vld, input bit full);
      bit eh;
      eh = (((vld & 1) != 0) && ovl(ch, cv, oh0, ov0)) ||
           (((vld & 2) != 0) && ovl(ch, cv, oh1, ov1));
      @(posedge clk); #1;
      car_h_pos = 10'(ch); car_v_pos = 9'(cv);
      obs_h[0] = 10'(oh0); obs_v[0] = 9'(ov0);
      obs_h[1] = 10'(oh1); obs_v[1] = 9'(ov1);
      obs_valid = 2'(vld);
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      scramble();
      @(posedge clk); #1;
      if (!eh && score_m < SMAX) score_m++;
      chk("hit", hit, eh);
      chk("score", score, score_m);
      chk("flash_t2", crash_flash, 0);
      @(posedge clk); #1;
      chk("flash_t3", crash_flash, eh);
      chk("over_t3", game_over, 0);
      if (eh && full) crash_and_restart();
   endtask

   initial begin
      int ch, cv;
      iRST = 1'b1; frame_tick = 1'b0; start_key = 1'b0;
      car_h_pos = '0; car_v_pos = '0; obs_h = '0; obs_v = '0; obs_valid = '0;
      repeat (3) @(posedge clk);
      #1 iRST = 1'b0;
      @(posedge clk); #1;
      chk("rst_reset_game", reset_game, 1);
      chk("rst_game_over", game_over, 0);
      chk("rst_flash", crash_flash, 0);
      chk("rst_hit", hit, 0);
      chk("rst_score", score, 0);

      start_game();

      for (int i = 0; i < 10; i++)
         run_frame(295, 400, 120, 100, $urandom_range(0, 1023), $urandom_range(0, 511), 1, 1'b1);
      chk("score_ten", score, 10);

      run_frame(295, 400, 345, 400, 245, 400, 3, 1'b1);
      run_frame(295, 400, 295, 480, 295, 320, 3, 1'b1);
      run_frame(295, 400, 344, 400, 0, 0, 1, 1'b1);

      for (int i = 0; i < 24; i++) begin
         ch = $urandom_range(0, 1023);
         cv = $urandom_range(0, 511);
         run_frame(ch, cv,
                   (ch + 924 + $urandom_range(0, 200)) % 1024, (cv + 412 + $urandom_range(0, 200)) % 512,
                   (ch + 924 + $urandom_range(0, 200)) % 1024, (cv + 412 + $urandom_range(0, 200)) % 512,
                   $urandom_range(0, 3), 1'b1);
      end

      run_frame(295, 400, 300, 350, 0, 0, 1, 1'b1);

      // reset in the middle of a crash sequence
      run_frame(295, 400, 300, 350, 0, 0, 1, 1'b0);
      repeat (5) tick_pulse();
      @(posedge clk); #1 iRST = 1'b1;
      @(posedge clk); #1 iRST = 1'b0;
      chk("midrst_reset_game", reset_game, 1);
      chk("midrst_game_over", game_over, 0);
      chk("midrst_flash", crash_flash, 0);
      chk("midrst_hit", hit, 0);
      chk("midrst_score", score, 0);
      score_m = 0;

      tick_pulse();
      repeat (2) @(posedge clk);
      #1;
      chk("idle_tick_score", score, 0);
      chk("idle_tick_rg", reset_game, 1);

      start_game();
      car_h_pos = 10'd295; car_v_pos = 9'd400;
      obs_h[0] = 10'd295; obs_v[0] = 9'd400; obs_valid = 2'b00;
      for (int n = 1; n <= 10000; n++) begin
         tick_pulse();
         @(posedge clk); #1;
         if (score_m < SMAX) score_m++;
         if (n >= 9998) begin
            chk("sat_score", score, score_m);
            chk("sat_hit", hit, 0);
         end
      end
      chk("sat_pinned", score, SMAX);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

`default_nettype wire
